// File: rtl/led_marker_monitor_if.sv
// LED marquee observation bus: the observed LED lines plus the decoded marker state.
// master drives led_in (bench/board side); slave is the monitor.
interface led_marker_monitor_if #(
  parameter int CW = 8
);
  logic [15:0]   led_in;
  logic [3:0]    pos1;
  logic [3:0]    pos3;
  logic          dir1;
  logic          dir3;
  logic          step1;
  logic          step3;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt3;
  logic          valid;
  logic          overlap;
  logic          err;

  modport master (
    output led_in,
    input  pos1, pos3, dir1, dir3, step1, step3, cnt1, cnt3, valid, overlap, err
  );

  modport slave (
    input  led_in,
    output pos1, pos3, dir1, dir3, step1, step3, cnt1, cnt3, valid, overlap, err
  );
endinterface

// File: rtl/led_marker_monitor.sv
// Two-marker LED marquee observer: synchronizes and debounces the bus, decodes both
// marker positions on each stable value, and tracks direction/step counts per marker.
module led_marker_monitor #(
  parameter int STABLE = 4,
  parameter int CW     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  led_marker_monitor_if.slave  bus
);
  localparam int CNT_W = $clog2(STABLE + 1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      s1_q, s2_q;
  logic [15:0]      cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pos1_q, pos1_d;
  logic [3:0]       pos3_q, pos3_d;
  logic             dir1_q, dir1_d;
  logic             dir3_q, dir3_d;
  logic             step1_q, step1_d;
  logic             step3_q, step3_d;
  logic [CW-1:0]    cnt1_q, cnt1_d;
  logic [CW-1:0]    cnt3_q, cnt3_d;
  logic             valid_q, valid_d;
  logic             ovl_q, ovl_d;
  logic             err_q, err_d;

  logic             commit;
  logic [4:0]       pc;
  logic [3:0]       iso;
  logic [3:0]       idx;
  logic             run3;
  logic             dec_ok;
  logic [3:0]       dec_p1;
  logic [3:0]       dec_p3;
  logic             dec_ovl;
  logic [3:0]       d1;
  logic [3:0]       d3;

  // Circular difference of 0 or +/-1 on the 16-position ring.
  function automatic logic within1(input logic [3:0] d);
    return (d == 4'd0) || (d == 4'd1) || (d == 4'd15);
  endfunction

  function automatic logic in_run3(input logic [3:0] p, input logic [3:0] start);
    logic [3:0] d;
    d = p - start;
    return d < 4'd3;
  endfunction

  assign commit = (s2_q == cand_q) && (cnt_q == CNT_W'(STABLE - 1));

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_W'(STABLE)) begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc      = '0;
    iso     = '0;
    idx     = '0;
    run3    = 1'b0;
    dec_ok  = 1'b0;
    dec_p1  = pos1_q;
    dec_p3  = pos3_q;
    dec_ovl = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pc = pc + 5'(cand_q[i]);
    end
    for (int i = 0; i < 16; i++) begin
      if (cand_q[i] && !cand_q[4'(i) - 4'd1] && !cand_q[4'(i) + 4'd1]) begin
        iso = 4'(i);
      end
    end
    // Each pattern class has at most one matching start index, so no priority issues.
    for (int i = 0; i < 16; i++) begin
      idx  = 4'(i);
      run3 = cand_q[idx] && cand_q[idx + 4'd1] && cand_q[idx + 4'd2];
      if (pc == 5'd4 && run3 && !cand_q[idx - 4'd1] && !cand_q[idx + 4'd3]) begin
        dec_ok = 1'b1;
        dec_p3 = idx + 4'd1;
        dec_p1 = iso;
      end else if (pc == 5'd4 && run3 && cand_q[idx + 4'd3]) begin
        if (within1(pos1_q - idx)) begin
          dec_ok = 1'b1;
          dec_p1 = idx;
          dec_p3 = idx + 4'd2;
        end else if (within1(pos1_q - (idx + 4'd3))) begin
          dec_ok = 1'b1;
          dec_p1 = idx + 4'd3;
          dec_p3 = idx + 4'd1;
        end
      end else if (pc == 5'd3 && run3) begin
        dec_ovl = 1'b1;
        dec_p3  = idx + 4'd1;
        if (in_run3(pos1_q, idx)) begin
          dec_ok = 1'b1;
          dec_p1 = pos1_q;
        end else if (in_run3(pos1_q + 4'd1, idx)) begin
          dec_ok = 1'b1;
          dec_p1 = pos1_q + 4'd1;
        end else if (in_run3(pos1_q - 4'd1, idx)) begin
          dec_ok = 1'b1;
          dec_p1 = pos1_q - 4'd1;
        end
      end
    end
  end

  assign d1 = dec_p1 - pos1_q;
  assign d3 = dec_p3 - pos3_q;

  always_comb begin
    state_d = state_q;
    pos1_d  = pos1_q;
    pos3_d  = pos3_q;
    dir1_d  = dir1_q;
    dir3_d  = dir3_q;
    step1_d = 1'b0;
    step3_d = 1'b0;
    cnt1_d  = cnt1_q;
    cnt3_d  = cnt3_q;
    valid_d = valid_q;
    ovl_d   = ovl_q;
    err_d   = err_q;
    if (commit) begin
      if (!dec_ok || (state_q == ST_LOCKED && !(within1(d1) && within1(d3)))) begin
        err_d   = 1'b1;
        valid_d = 1'b0;
      end else begin
        err_d   = 1'b0;
        valid_d = 1'b1;
        ovl_d   = dec_ovl;
        pos1_d  = dec_p1;
        pos3_d  = dec_p3;
        state_d = ST_LOCKED;
        // The first lock after reset only loads positions.
        if (state_q == ST_LOCKED) begin
          if (d1 != 4'd0) begin
            step1_d = 1'b1;
            dir1_d  = (d1 == 4'd1);
            cnt1_d  = cnt1_q + CW'(1);
          end
          if (d3 != 4'd0) begin
            step3_d = 1'b1;
            dir3_d  = (d3 == 4'd1);
            cnt3_d  = cnt3_q + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNLOCKED;
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      pos1_q  <= 4'd15;
      pos3_q  <= 4'd14;
      dir1_q  <= 1'b0;
      dir3_q  <= 1'b0;
      step1_q <= 1'b0;
      step3_q <= 1'b0;
      cnt1_q  <= '0;
      cnt3_q  <= '0;
      valid_q <= 1'b0;
      ovl_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= bus.led_in;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pos1_q  <= pos1_d;
      pos3_q  <= pos3_d;
      dir1_q  <= dir1_d;
      dir3_q  <= dir3_d;
      step1_q <= step1_d;
      step3_q <= step3_d;
      cnt1_q  <= cnt1_d;
      cnt3_q  <= cnt3_d;
      valid_q <= valid_d;
      ovl_q   <= ovl_d;
      err_q   <= err_d;
    end
  end

  assign bus.pos1    = pos1_q;
  assign bus.pos3    = pos3_q;
  assign bus.dir1    = dir1_q;
  assign bus.dir3    = dir3_q;
  assign bus.step1   = step1_q;
  assign bus.step3   = step3_q;
  assign bus.cnt1    = cnt1_q;
  assign bus.cnt3    = cnt3_q;
  assign bus.valid   = valid_q;
  assign bus.overlap = ovl_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_led_marker_monitor.sv
// Bench for led_marker_monitor: directed marquee scenarios followed by randomized
// marker motion, junk patterns and resets, every cycle compared to a reference model.
module tb_led_marker_monitor;
  localparam int STABLE = 4;
  localparam int CW     = 8;
  localparam int CMAX   = 1 << CW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_marker_monitor_if #(.CW(CW)) bus ();
  led_marker_monitor #(.STABLE(STABLE), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  int m_pos1, m_pos3, m_dir1, m_dir3, m_step1, m_step3;
  int m_cnt1, m_cnt3, m_valid, m_ovl, m_err;
  bit m_locked;

  // A bus value commits once it has been sampled STABLE+1 edges in a row;
  // the outputs show it two edges after that last sample.
  logic [15:0] last_samp;
  int          run_len;
  bit          pend_ok[2];
  logic [15:0] pend_v[2];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cdist(input int a, input int b);
    int d;
    d = (a - b + 16) % 16;
    return (d > 8) ? 16 - d : d;
  endfunction

  function automatic bit in_run(input int x, input int a);
    return ((x - a + 32) % 16) < 3;
  endfunction

  function automatic void ref_decode(input logic [15:0] v, input int prev1,
                                     output bit ok, output int p1, output int p3, output bit ov);
    int pc;
    int starts[$];
    int lens[$];
    int len;
    pc = $countones(v);
    ok = 0; p1 = prev1; p3 = 0; ov = 0;
    for (int s = 0; s < 16; s++) begin
      if (v[s] && !v[(s + 15) % 16]) begin
        len = 0;
        while (len < 16 && v[(s + len) % 16]) len++;
        starts.push_back(s);
        lens.push_back(len);
      end
    end
    if (pc == 4 && starts.size() == 2 && ((lens[0] == 3 && lens[1] == 1) || (lens[0] == 1 && lens[1] == 3))) begin
      ok = 1;
      if (lens[0] == 3) begin p3 = (starts[0] + 1) % 16; p1 = starts[1]; end
      else              begin p3 = (starts[1] + 1) % 16; p1 = starts[0]; end
    end else if (pc == 4 && starts.size() == 1) begin
      if (cdist(prev1, starts[0]) <= 1) begin
        ok = 1; p1 = starts[0]; p3 = (starts[0] + 2) % 16;
      end else if (cdist(prev1, (starts[0] + 3) % 16) <= 1) begin
        ok = 1; p1 = (starts[0] + 3) % 16; p3 = (starts[0] + 1) % 16;
      end
    end else if (pc == 3 && starts.size() == 1) begin
      ov = 1;
      p3 = (starts[0] + 1) % 16;
      if (in_run(prev1, starts[0]))           begin ok = 1; p1 = prev1; end
      else if (in_run(prev1 + 1, starts[0]))  begin ok = 1; p1 = (prev1 + 1) % 16; end
      else if (in_run(prev1 + 15, starts[0])) begin ok = 1; p1 = (prev1 + 15) % 16; end
    end
  endfunction

  task automatic model_edge();
    bit ok, ov, cur;
    int p1, p3, dd1, dd3;
    logic [15:0] cv;
    if (rst) begin
      m_pos1 = 15; m_pos3 = 14; m_dir1 = 0; m_dir3 = 0; m_step1 = 0; m_step3 = 0;
      m_cnt1 = 0; m_cnt3 = 0; m_valid = 0; m_ovl = 0; m_err = 0; m_locked = 0;
      last_samp = '0;
      run_len = 3;
      pend_ok[1] = 0;
      pend_ok[0] = (run_len == STABLE + 1);
      pend_v[0] = '0;
      pend_v[1] = '0;
      return;
    end
    cur = pend_ok[1];
    cv  = pend_v[1];
    pend_ok[1] = pend_ok[0];
    pend_v[1]  = pend_v[0];
    if (bus.led_in == last_samp) begin
      if (run_len < 1000) run_len++;
    end else begin
      last_samp = bus.led_in;
      run_len = 1;
    end
    pend_ok[0] = (run_len == STABLE + 1);
    pend_v[0]  = last_samp;
    m_step1 = 0;
    m_step3 = 0;
    if (cur) begin
      ref_decode(cv, m_pos1, ok, p1, p3, ov);
      dd1 = (p1 - m_pos1 + 16) % 16;
      dd3 = (p3 - m_pos3 + 16) % 16;
      if (ok && m_locked && !((dd1 == 0 || dd1 == 1 || dd1 == 15) && (dd3 == 0 || dd3 == 1 || dd3 == 15)))
        ok = 0;
      if (!ok) begin
        m_err = 1; m_valid = 0;
      end else begin
        if (m_locked) begin
          if (dd1 != 0) begin m_step1 = 1; m_dir1 = (dd1 == 1); m_cnt1 = (m_cnt1 + 1) % CMAX; end
          if (dd3 != 0) begin m_step3 = 1; m_dir3 = (dd3 == 1); m_cnt3 = (m_cnt3 + 1) % CMAX; end
        end
        m_pos1 = p1; m_pos3 = p3; m_ovl = ov;
        m_valid = 1; m_err = 0; m_locked = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("pos1", bus.pos1, m_pos1);
    chk("pos3", bus.pos3, m_pos3);
    chk("dir1", bus.dir1, m_dir1);
    chk("dir3", bus.dir3, m_dir3);
    chk("step1", bus.step1, m_step1);
    chk("step3", bus.step3, m_step3);
    chk("cnt1", bus.cnt1, m_cnt1);
    chk("cnt3", bus.cnt3, m_cnt3);
    chk("valid", bus.valid, m_valid);
    chk("overlap", bus.overlap, m_ovl);
    chk("err", bus.err, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input logic [15:0] v, input int n);
    bus.led_in = v;
    repeat (n) tick();
  endtask

  function automatic logic [15:0] marq(input int p1, input int p3);
    logic [15:0] v;
    v = '0;
    v[p1 % 16] = 1'b1;
    v[(p3 + 15) % 16] = 1'b1;
    v[p3 % 16] = 1'b1;
    v[(p3 + 1) % 16] = 1'b1;
    return v;
  endfunction

  initial begin
    int g1, g3, r;
    rst = 1'b1;
    bus.led_in = '0;
    repeat (3) tick();
    chk("rst_pos1", bus.pos1, 15);
    chk("rst_pos3", bus.pos3, 14);
    chk("rst_valid", bus.valid, 0);

    rst = 1'b0;
    bus.led_in = 16'h0071;
    repeat (6) tick();
    chk("lat_before_valid", bus.valid, 0);
    tick();
    chk("lat_valid", bus.valid, 1);
    chk("basic_pos1", bus.pos1, 0);
    chk("basic_pos3", bus.pos3, 5);
    chk("basic_nostep", bus.step1, 0);
    hold(16'h0071, 2);

    hold(16'h0072, 9);
    chk("step_cnt1", bus.cnt1, 1);
    chk("step_dir1", bus.dir1, 1);
    hold(16'h00E2, 9);
    chk("step_pos3", bus.pos3, 6);
    chk("step_dir3", bus.dir3, 1);
    hold(16'h0071, 9);
    hold(16'h8070, 9);
    chk("wrap_pos1", bus.pos1, 15);
    chk("wrap_dir1", bus.dir1, 0);
    hold(16'h0071, 9);
    hold(16'h0074, 9);
    chk("jump_err", bus.err, 1);
    chk("jump_valid", bus.valid, 0);
    chk("jump_pos1", bus.pos1, 0);
    chk("jump_cnt1", bus.cnt1, 4);

    hold(16'h0071, 9);
    hold(16'h0072, 3);
    hold(16'h0071, 9);
    chk("glitch_pos1", bus.pos1, 0);
    chk("glitch_cnt1", bus.cnt1, 4);
    chk("glitch_valid", bus.valid, 1);
    hold(16'h0000, 9);
    chk("zero_err", bus.err, 1);

    hold(16'h0071, 9);
    hold(16'h0072, 9);
    hold(16'h0074, 9);
    hold(16'h0078, 9);
    chk("ambig_b_pos1", bus.pos1, 3);
    chk("ambig_b_pos3", bus.pos3, 5);
    chk("ambig_b_cnt1", bus.cnt1, 7);
    hold(16'h0070, 9);
    chk("ambig_c_ovl", bus.overlap, 1);
    chk("ambig_c_pos1", bus.pos1, 4);

    hold(16'h0072, 2);
    rst = 1'b1;
    tick();
    chk("midrst_pos1", bus.pos1, 15);
    chk("midrst_cnt1", bus.cnt1, 0);
    chk("midrst_valid", bus.valid, 0);
    rst = 1'b0;
    hold(16'h0072, 9);
    chk("relock_pos1", bus.pos1, 1);
    chk("relock_cnt1", bus.cnt1, 0);
    chk("relock_valid", bus.valid, 1);

    g1 = 1; g3 = 5;
    for (int seg = 0; seg < 400; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        hold(16'($urandom), $urandom_range(2, 9));
      end else if (r < 6) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        if (r < 10) g1 = $urandom_range(0, 15);
        else g1 = (g1 + 16 + $urandom_range(0, 2) - 1) % 16;
        g3 = (g3 + 16 + $urandom_range(0, 2) - 1) % 16;
        hold(marq(g1, g3), $urandom_range(3, 9));
      end
    end
    hold(marq(g1, g3), 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/led_marker_monitor.md
# led_marker_monitor

Observer for the 16-LED two-marker marquee bus: a single-LED marker and a three-LED marker centred on its own position, both rotating around 16 positions. It samples the LED bus in the system clock domain, debounces it, and decodes both marker positions. It then tracks step direction and step counts per marker and flags illegal patterns or jumps. It sits beside the marquee generator and feeds on-board self-check logic and the verification scoreboard.

## Interface
- `STABLE`, default 4: cycles the synchronized bus must hold before a decode commit; legal range ≥2.
- `CW`, default 8: width of each step counter.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `led_in` in 16: LED bus under observation; may change asynchronously to `clk`.
- `pos1` out 4: decoded single-marker position.
- `pos3` out 4: decoded centre of the three-LED marker.
- `dir1`, `dir3` out 1 each: last step direction; 1 means +1 (up), 0 means −1 (down).
- `step1`, `step3` out 1 each: one-cycle pulse on a committed step.
- `cnt1`, `cnt3` out CW each: step counters; wrap modulo 2^CW.
- `valid` out 1: last commit decoded cleanly.
- `overlap` out 1: last commit had the single marker inside the three-LED run.
- `err` out 1: last commit was illegal (bad pattern or jump).

## Operation
- **Input path:**
  - Two-flop synchronizer `s1` → `s2`.
  - Candidate register `cand` and counter `cnt` saturating at STABLE.
  - If `s2 != cand`: `cand <= s2`, `cnt <= 0`.
  - Otherwise `cnt` increments, saturating.
  - Commit fires once per stable value, on the edge where `cnt` goes STABLE−1 → STABLE.
- **Decode of `cand`** (all indices circular mod 16):
  - **A.** Popcount 4, one run of 3 plus one isolated bit: `pos3` = run middle, `pos1` = isolated bit, `overlap` = 0.
  - **B.** Popcount 4 as a single run a..a+3:
    - If the previous `pos1` is within circular distance ≤1 of a: `pos1` = a, `pos3` = a+2.
    - Else if within ≤1 of a+3: `pos1` = a+3, `pos3` = a+1.
    - Else: err.
    - `overlap` = 0.
  - **C.** Popcount 3 as a run of 3: `pos3` = middle, `overlap` = 1.
    - `pos1` = previous `pos1` if it is in the run.
    - Else previous+1 if in the run, else previous−1 if in the run.
    - Else err.
  - **D.** Anything else, including all-zero: err.
- **Step check**, per marker, on a legal decode, with d = new − old mod 16:
  - d = 0: no step.
  - d = 1: step pulse, `dir` ← 1, count+1.
  - d = 15: step pulse, `dir` ← 0, count+1.
  - Any other d: err.
- **First legal commit after reset** (internal `locked` = 0): load positions with no step check, no pulses and no jump error; then set `locked`.
- **On err:**
  - `err` = 1, `valid` = 0.
  - `pos*`, `dir*` and `cnt*` hold; no pulses.
  - `overlap` holds.
- **On legal commit:** `valid` = 1, `err` = 0. Flags hold until the next commit.

## Timing
- **Reset values:** `pos1` = 15, `pos3` = 14, `dir1` = `dir3` = 0, `step*` = 0, `cnt*` = 0, `valid` = `overlap` = `err` = 0. Internally `locked` = 0, `s1` = `s2` = `cand` = 0, `cnt` = 0.
- **Latency:** if edge 1 is the first edge sampling a new `led_in` value, registered outputs update on edge STABLE+3 (edge 7 at default).
- **Glitch rejection:** a value held for fewer than STABLE+1 sampled cycles after reaching `s2` never commits.
- **Step pulses:** high for exactly one cycle, the cycle after the commit edge.
- **Simultaneous steps:** `step1` and `step3` may pulse together.
- **Reset:** `rst` asserted mid-debounce discards `cand` and `cnt`; `rst` has priority over commit.

## Test plan
- **Basic decode:** reset, then hold `led_in` = 0x0071 → at edge 7: `pos1` = 0, `pos3` = 5, `valid` = 1, no step pulse (first lock).
- **Steps and wrap-around:**
  - 0x0071 → 0x0072: `step1` pulse, `dir1` = 1, `cnt1` = 1.
  - Then 0x00E2: `step3` pulse, `dir3` = 1, `pos3` = 6.
  - Then from 0x0071, apply 0x8070: `pos1` = 15, `dir1` = 0.
- **Ambiguous patterns:**
  - From `pos1` = 2, `pos3` = 5, apply 0x0078 → class B: `pos1` = 3, `pos3` = 5, `step1` pulse.
  - 0x0070 with previous `pos1` = 5 → `overlap` = 1, `pos1` = 5.
- **Jump and illegal patterns:**
  - 0x0071 → 0x0074: `err` = 1, `valid` = 0, `pos1` stays 0, `cnt1` unchanged.
  - 0x0000: `err` = 1.
- **Glitch:** a 0x0072 pulse held 3 cycles between 0x0071 holds → no commit, no step, outputs unchanged.
- **Reset mid-operation:** assert `rst` during a debounce → all outputs return to reset values the next edge; the following commit re-locks without a pulse.
